vga_text_ctrl: RTL and testbench

- 80x30 character text-mode controller for 640x480@60 VGA; directly upstream of the 8x16 font ROM (pc_vga_8x16_00_7F).
- Generates pixel timing, holds a 2400-cell text buffer with a CPU write port, and drives the font ROM's ascii_code/row/col.
- Consumes the ROM's single pixel bit, applies per-cell fg/bg colour through a fixed 16-entry palette, and emits registered RGB plus syncs.

---
 rtl/vga_text_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_vga_text_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_ctrl.sv
// 80x30 text-mode VGA controller: pixel timing, 2400-cell text RAM with CPU write port,
// font ROM addressing and CGA palette lookup, all advancing on a clk/2 pixel strobe.
module vga_text_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic [6:0]  font_ascii,
    output logic [3:0]  font_row,
    output logic [2:0]  font_col,
    input  logic        font_pixel,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        frame_start
);

    localparam logic [9:0]  H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0]  HS_LO  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_LO  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] CELLS  = 12'd2400;
    localparam logic [11:0] COLS   = 12'd80;

    function automatic logic [11:0] palette(input logic [3:0] idx);
        logic [11:0] c;
        case (idx)
            4'd0:    c = 12'h000;
            4'd1:    c = 12'h00A;
            4'd2:    c = 12'h0A0;
            4'd3:    c = 12'h0AA;
            4'd4:    c = 12'hA00;
            4'd5:    c = 12'hA0A;
            4'd6:    c = 12'hA50;
            4'd7:    c = 12'hAAA;
            4'd8:    c = 12'h555;
            4'd9:    c = 12'h55F;
            4'd10:   c = 12'h5F5;
            4'd11:   c = 12'h5FF;
            4'd12:   c = 12'hF55;
            4'd13:   c = 12'hF5F;
            4'd14:   c = 12'hFF5;
            default: c = 12'hFFF;
        endcase
        return c;
    endfunction

    logic        r_phase;
    logic [9:0]  r_h, r_v;
    logic        r_frame_start;

    logic        r_s1_vld, r_s1_vis, r_s1_hs, r_s1_vs;
    logic [2:0]  r_s1_hcol;
    logic [3:0]  r_s1_vrow;
    logic [11:0] r_s1_addr;

    logic        r_s2_vld, r_s2_vis, r_s2_hs, r_s2_vs;
    logic [3:0]  r_s2_fg, r_s2_bg;
    logic [6:0]  r_font_ascii;
    logic [3:0]  r_font_row;
    logic [2:0]  r_font_col;

    logic [11:0] r_rgb;
    logic        r_hs, r_vs, r_de;

    logic [15:0] r_ram [0:2399];
    logic [15:0] r_rdata;

    logic        w_visible, w_hs, w_vs;
    logic [11:0] w_addr;
    logic [11:0] w_rgb;
    logic        w_unused_attr;

    assign w_visible = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hs      = !((r_h >= HS_LO) && (r_h <= HS_HI));
    assign w_vs      = !((r_v >= VS_LO) && (r_v <= VS_HI));
    // Blanking-area addresses are parked at 0 so the RAM index never exceeds 2399.
    assign w_addr    = w_visible ? (12'(r_v[9:4]) * COLS + 12'(r_h[9:3])) : 12'd0;
    assign w_rgb     = r_s2_vis ? palette(font_pixel ? r_s2_fg : r_s2_bg) : 12'h000;
    assign w_unused_attr = r_rdata[7];

    // Read-first text RAM; the read runs every clk, the pipeline picks it up on pix_step.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < CELLS))
            r_ram[wr_addr] <= wr_data;
        r_rdata <= r_ram[r_s1_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase       <= 1'b0;
            r_h           <= '0;
            r_v           <= '0;
            r_frame_start <= 1'b0;
            r_s1_vld      <= 1'b0;
            r_s1_vis      <= 1'b0;
            r_s1_hs       <= 1'b1;
            r_s1_vs       <= 1'b1;
            r_s1_hcol     <= '0;
            r_s1_vrow     <= '0;
            r_s1_addr     <= '0;
            r_s2_vld      <= 1'b0;
            r_s2_vis      <= 1'b0;
            r_s2_hs       <= 1'b1;
            r_s2_vs       <= 1'b1;
            r_s2_fg       <= '0;
            r_s2_bg       <= '0;
            r_font_ascii  <= '0;
            r_font_row    <= '0;
            r_font_col    <= '0;
            r_rgb         <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_de          <= 1'b0;
        end else begin
            r_phase       <= ~r_phase;
            r_frame_start <= !r_phase && (r_h == 10'd0) && (r_v == 10'd0);
            if (r_phase) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end

                r_s1_vld  <= 1'b1;
                r_s1_hcol <= r_h[2:0];
                r_s1_vrow <= r_v[3:0];
                r_s1_vis  <= w_visible;
                r_s1_hs   <= w_hs;
                r_s1_vs   <= w_vs;
                r_s1_addr <= w_addr;

                // Font address is only touched on pix_step, so the ROM sees it for 2 clks.
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_font_ascii <= r_rdata[6:0];
                    r_font_row   <= r_s1_vrow;
                    r_font_col   <= r_s1_hcol;
                    r_s2_fg      <= r_rdata[11:8];
                    r_s2_bg      <= r_rdata[15:12];
                    r_s2_vis     <= r_s1_vis;
                    r_s2_hs      <= r_s1_hs;
                    r_s2_vs      <= r_s1_vs;
                end

                if (r_s2_vld) begin
                    r_rgb <= w_rgb;
                    r_hs  <= r_s2_hs;
                    r_vs  <= r_s2_vs;
                    r_de  <= r_s2_vis;
                end
            end
        end
    end

    assign font_ascii  = r_font_ascii;
    assign font_row    = r_font_row;
    assign font_col    = r_font_col;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_de      = r_de;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Bench for vga_text_ctrl on a shrunken raster (8x2 visible cells) with a font ROM stand-in.
// A pixel-index model predicts every output cycle; directed literals pin key pixels and timing.
module tb_vga_text_ctrl;

    localparam int HA = 64, HF = 8, HS = 16, HB = 8;
    localparam int VA = 32, VF = 3, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic [6:0]  font_ascii;
    logic [3:0]  font_row;
    logic [2:0]  font_col;
    logic        font_pixel;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de, frame_start;

    int checks = 0;
    int failures = 0;

    vga_text_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .font_ascii(font_ascii), .font_row(font_row), .font_col(font_col),
        .font_pixel(font_pixel),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] glyph(input logic [6:0] a, input logic [3:0] r);
        logic [7:0] g;
        g = 8'h00;
        if (a == 7'h41) begin
            case (r)
                4'd3: g = 8'h10;  4'd4: g = 8'h38;  4'd5: g = 8'h6C;
                4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12: g = 8'hC6;
                4'd8: g = 8'hFE;
                default: g = 8'h00;
            endcase
        end else if (a == 7'h42) begin
            case (r)
                4'd3, 4'd12: g = 8'hFC;
                4'd7: g = 8'h7C;
                4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: g = 8'h66;
                default: g = 8'h00;
            endcase
        end else if (a != 7'h00) begin
            g = (8'(a) * 8'd37) ^ (8'(r) * 8'd19) ^ 8'h5A;
        end
        return g;
    endfunction

    function automatic logic [11:0] pal(input logic [3:0] i);
        logic [11:0] t [16];
        t = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
              12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
        return t[i];
    endfunction

    // Font ROM stand-in: glyph row registered on the clk after the address, bit picked by col.
    logic [7:0] rom_row;
    always @(posedge clk) rom_row <= glyph(font_ascii, font_row);
    assign font_pixel = rom_row[7 - int'(font_col)];

    // Model: n = clks since the last reset edge; pixel k enters the counters at n = 2k,
    // its cell is read (read-first) at n = 2k+3, font address shows at 2k+4, outputs at 2k+6.
    int          n = 0;
    logic [15:0] mem [0:2399];
    logic [15:0] snap [4];

    always @(posedge clk) begin
        int k, ph, pv;
        if (rst) n = 0;
        else     n = n + 1;
        if (n >= 3 && (n % 2) == 1) begin
            k  = ((n - 3) / 2) % FRAME;
            ph = k % HT;
            pv = k / HT;
            snap[((n - 3) / 2) % 4] = (ph < HA && pv < VA) ? mem[(pv / 16) * 80 + ph / 8] : 16'h0000;
        end
        if (wr_en && int'(wr_addr) < 2400) mem[wr_addr] = wr_data;
    end

    logic [6:0] prev_ascii;
    logic [3:0] prev_row;
    logic [2:0] prev_col;

    always @(negedge clk) begin
        int k, ph, pv;
        logic [15:0] c;
        logic [7:0]  g;
        logic [11:0] e_rgb;
        logic        e_hs, e_vs, e_de, e_fs, vis;
        e_fs = (n % (2 * FRAME)) == 1;
        if (n < 6) begin
            e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
        end else begin
            k   = ((n - 6) / 2) % FRAME;
            ph  = k % HT;
            pv  = k / HT;
            c   = snap[((n - 6) / 2) % 4];
            vis = ph < HA && pv < VA;
            g   = glyph(c[6:0], 4'(pv % 16));
            e_de  = vis;
            e_hs  = !(ph >= HA + HF && ph < HA + HF + HS);
            e_vs  = !(pv >= VA + VF && pv < VA + VF + VS);
            e_rgb = vis ? pal(g[7 - (ph % 8)] ? c[11:8] : c[15:12]) : 12'h000;
        end
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start} !== {e_rgb, e_hs, e_vs, e_de, e_fs}) begin
            failures++;
            $display("FAIL model_out n=%0d rgb=%h hs=%b vs=%b de=%b fs=%b expected rgb=%h hs=%b vs=%b de=%b fs=%b",
                     n, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_de, frame_start, e_rgb, e_hs, e_vs, e_de, e_fs);
        end
        if (n < 4) begin
            checks++;
            if ({font_ascii, font_row, font_col} !== 14'd0) begin
                failures++;
                $display("FAIL font_idle n=%0d got %h/%h/%h expected 0/0/0", n, font_ascii, font_row, font_col);
            end
        end else begin
            k  = ((n - 4) / 2) % FRAME;
            ph = k % HT;
            pv = k / HT;
            c  = snap[((n - 4) / 2) % 4];
            if (ph < HA && pv < VA) begin
                checks++;
                if ({font_ascii, font_row, font_col} !== {c[6:0], 4'(pv % 16), 3'(ph % 8)}) begin
                    failures++;
                    $display("FAIL font_addr n=%0d got %h/%h/%h expected %h/%h/%h",
                             n, font_ascii, font_row, font_col, c[6:0], 4'(pv % 16), 3'(ph % 8));
                end
            end
        end
        if ((n % 2) == 1) begin
            checks++;
            if ({font_ascii, font_row, font_col} !== {prev_ascii, prev_row, prev_col}) begin
                failures++;
                $display("FAIL font_hold n=%0d got %h/%h/%h held %h/%h/%h",
                         n, font_ascii, font_row, font_col, prev_ascii, prev_row, prev_col);
            end
        end
        prev_ascii = font_ascii;
        prev_row   = font_row;
        prev_col   = font_col;
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got %h expected %h", nm, n, act, exp);
        end
    endtask

    task automatic wait_n(input int target);
        for (int i = 0; i < 60000 && n != target; i++) @(negedge clk);
        if (n != target) begin
            failures++;
            checks++;
            $display("FAIL wait_n reached %0d expected %0d", n, target);
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        $display("write addr=%0d data=%h", a, d);
    endtask

    initial begin
        logic [15:0] d;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            d = {4'(i % 16), 4'((i * 7 + 3) % 16), 1'b1, 7'(i * 5 + 33)};
            wr_en = 1'b1; wr_addr = 12'(i); wr_data = d;
            @(negedge clk);
        end
        wr_en = 1'b0;
        do_write(12'd0, 16'h0F41);
        do_write(12'd1, 16'h0F42);
        do_write(12'd87, 16'h1E00);
        do_write(12'd2400, 16'h4F7F);
        do_write(12'd4095, 16'h4F7F);
        lit("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        lit("reset_sync", 32'({vga_hs, vga_vs, vga_de, frame_start}), 32'b1100);
        lit("reset_font", 32'({font_ascii, font_row, font_col}), 32'h0);
        rst = 1'b0;

        wait_n(1);    lit("fs_first", 32'(frame_start), 32'd1);
        wait_n(2);    lit("fs_pulse_end", 32'(frame_start), 32'd0);
        wait_n(5);    lit("de_before_first", 32'(vga_de), 32'd0);
        wait_n(6);    lit("de_first", 32'(vga_de), 32'd1);
        wait_n(148);  lit("hs_h71", 32'(vga_hs), 32'd1);
        wait_n(150);  lit("hs_h72", 32'(vga_hs), 32'd0);
        wait_n(180);  lit("hs_h87", 32'(vga_hs), 32'd0);
        wait_n(182);  lit("hs_h88", 32'(vga_hs), 32'd1);
        wait_n(586);  lit("A_row3_px2", 32'({vga_r, vga_g, vga_b}), 32'h000);
        wait_n(588);  lit("A_row3_px3", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
        wait_n(596);  lit("A_row3_px7", 32'({vga_r, vga_g, vga_b}), 32'h000);
        wait_n(598);  lit("B_row3_px8", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
        wait_n(3190); lit("last_cell_first", 32'({vga_r, vga_g, vga_b}), 32'h00A);
        wait_n(6084); lit("last_cell_last", 32'({vga_r, vga_g, vga_b, vga_de}), 32'h0015);
        wait_n(6086); lit("right_of_active", 32'({vga_r, vga_g, vga_b, vga_de}), 32'h0);
        wait_n(6150); lit("below_active", 32'({vga_r, vga_g, vga_b, vga_de}), 32'h0);
        wait_n(6724); lit("vs_line34", 32'(vga_vs), 32'd1);
        wait_n(6726); lit("vs_line35", 32'(vga_vs), 32'd0);
        wait_n(7108); lit("vs_line36", 32'(vga_vs), 32'd0);
        wait_n(7110); lit("vs_line37", 32'(vga_vs), 32'd1);
        wait_n(7681); lit("fs_frame1", 32'(frame_start), 32'd1);

        // Write lands on the same clk that reads cell 0 for pixel (0,3) of frame 1.
        wait_n(8258);
        do_write(12'd0, 16'h2F41);
        wait_n(8262); lit("collision_old", 32'({vga_r, vga_g, vga_b}), 32'h000);
        wait_n(8264); lit("collision_new", 32'({vga_r, vga_g, vga_b}), 32'h0A0);

        wait_n(19280);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lit("midrst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        lit("midrst_sync", 32'({vga_hs, vga_vs, vga_de, frame_start}), 32'b1100);
        lit("midrst_font", 32'({font_ascii, font_row, font_col}), 32'h0);
        wait_n(1);    lit("midrst_fs", 32'(frame_start), 32'd1);
        wait_n(5);    lit("midrst_de_wait", 32'(vga_de), 32'd0);
        wait_n(6);    lit("midrst_de_first", 32'(vga_de), 32'd1);
        wait_n(7681); lit("midrst_fs_next", 32'(frame_start), 32'd1);
        wait_n(7700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
